// File: rtl/sm_debug_display_pkg.sv
// sm_debug_display_pkg: segment glyphs and the hex-to-segment helper for the debug display
package sm_debug_display_pkg;
   // Segment bits are {G,F,E,D,C,B,A}, active low
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      return GLYPH[n];
   endfunction
endpackage

// File: rtl/sm_debounce.sv
// sm_debounce: 2-FF synchroniser plus stability counter; ports clkIn, rst_n, raw in, stable level and 1-cycle press pulse out
module sm_debounce #(
   parameter int DEB_W = 20
) (
   input  logic clkIn,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic press
);
   logic [1:0]       sync;
   logic [DEB_W-1:0] cnt;
   always_ff @(posedge clkIn or negedge rst_n)
      if (!rst_n) begin
         sync   <= '0;
         cnt    <= '0;
         stable <= 1'b0;
         press  <= 1'b0;
      end else begin
         sync  <= {sync[0], raw};
         press <= 1'b0;
         if (sync[1] == stable)
            cnt <= '0;
         else if (&cnt) begin
            // input has disagreed for 2**DEB_W cycles: accept it; a rising accept is a press
            stable <= sync[1];
            press  <= sync[1];
            cnt    <= '0;
         end else
            cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/sm_debug_display.sv
// sm_debug_display: scanned 7-segment readout of one of NUM_SRC debug words; ports clkIn, rst_n, src_data, btn_next/prev, force_sel_en/force_sel in; seven_segments, dot, anodes, sel_o out
module sm_debug_display
   import sm_debug_display_pkg::*;
#(
   parameter  int DIGITS   = 8,
   parameter  int NUM_SRC  = 4,
   parameter  int SCAN_DIV = 16,
   parameter  int DEB_W    = 20,
   parameter  int LZ_BLANK = 1,
   localparam int W        = 4 * DIGITS,
   localparam int SEL_W    = $clog2(NUM_SRC)
) (
   input  logic                 clkIn,
   input  logic                 rst_n,
   input  logic [NUM_SRC*W-1:0] src_data,
   input  logic                 btn_next,
   input  logic                 btn_prev,
   input  logic                 force_sel_en,
   input  logic [SEL_W-1:0]     force_sel,
   output logic [6:0]           seven_segments,
   output logic                 dot,
   output logic [DIGITS-1:0]    anodes,
   output logic [SEL_W-1:0]     sel_o
);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = $clog2(SCAN_DIV);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_SRC - 1);
   localparam logic [IW-1:0]    LAST_IDX = IW'(DIGITS - 1);
   localparam logic [PW-1:0]    LAST_PRE = PW'(SCAN_DIV - 1);

   logic              next_p, prev_p, unused_next_stable, unused_prev_stable;
   logic [SEL_W-1:0]  sel, sel_nxt;
   logic [IW-1:0]     idx;
   logic [PW-1:0]     pre;
   logic [W-1:0]      snap;
   logic              blank;

   sm_debounce #(.DEB_W(DEB_W)) u_next (
      .clkIn(clkIn), .rst_n(rst_n), .raw(btn_next), .stable(unused_next_stable), .press(next_p)
   );
   sm_debounce #(.DEB_W(DEB_W)) u_prev (
      .clkIn(clkIn), .rst_n(rst_n), .raw(btn_prev), .stable(unused_prev_stable), .press(prev_p)
   );

   // Forcing swallows button presses; simultaneous presses cancel
   always_comb
      sel_nxt = force_sel_en ? ((32'(force_sel) >= NUM_SRC) ? LAST_SEL : force_sel)
              : (next_p & prev_p) ? sel
              : next_p ? ((sel == LAST_SEL) ? '0 : sel + 1'b1)
              : prev_p ? ((sel == '0) ? LAST_SEL : sel - 1'b1)
              : sel;

   // Leading-zero digit: this nibble and every more significant one are zero
   always_comb
      blank = (LZ_BLANK != 0) && (idx != '0) && ((snap >> (32'(idx) * 4)) == '0);

   always_ff @(posedge clkIn or negedge rst_n)
      if (!rst_n) begin
         sel            <= '0;
         sel_o          <= '0;
         idx            <= '0;
         pre            <= '0;
         snap           <= '0;
         anodes         <= '1;
         seven_segments <= SEG_BLANK;
         dot            <= 1'b1;
      end else begin
         sel   <= sel_nxt;
         sel_o <= sel;
         // A new selection restarts the frame with a fresh snapshot so words never mix
         if (sel_nxt != sel) begin
            snap <= src_data[32'(sel_nxt) * W +: W];
            idx  <= '0;
            pre  <= '0;
         end else if (pre == LAST_PRE) begin
            pre <= '0;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            if (idx == LAST_IDX)
               snap <= src_data[32'(sel) * W +: W];
         end else
            pre <= pre + 1'b1;
         anodes         <= ~(DIGITS'(1) << idx);
         seven_segments <= blank ? SEG_BLANK : hex_seg(snap[32'(idx) * 4 +: 4]);
         dot            <= (32'(idx) != 32'(sel));
      end
endmodule

// File: tb/tb_sm_debug_display.sv
// tb_sm_debug_display: directed table and sequence checks of the debug display
module tb_sm_debug_display;
   logic         clk = 1'b0, rst_n = 1'b0;
   logic [127:0] src_data = '0, zero_data = '0;
   logic         btn_next = 1'b0, btn_prev = 1'b0, force_sel_en = 1'b0, tie0 = 1'b0;
   logic [1:0]   force_sel = '0, tie_sel = '0;
   logic [6:0]   seven_segments, seg2;
   logic         dot, dot2, found;
   logic [7:0]   anodes, anodes2;
   logic [1:0]   sel_o, sel2;
   int           n_chk = 0, n_fail = 0;
   logic [6:0]   glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [7:0][6:0] m1;

   typedef struct packed {
      logic [1:0]      sel;
      logic [31:0]     word;
      logic [7:0][6:0] seg;
   } vec_t;
   vec_t tv [6];

   always #5 clk = ~clk;

   sm_debug_display #(.DIGITS(8), .NUM_SRC(4), .SCAN_DIV(4), .DEB_W(3), .LZ_BLANK(1)) dut (
      .clkIn(clk), .rst_n(rst_n), .src_data(src_data), .btn_next(btn_next), .btn_prev(btn_prev),
      .force_sel_en(force_sel_en), .force_sel(force_sel), .seven_segments(seven_segments),
      .dot(dot), .anodes(anodes), .sel_o(sel_o)
   );

   sm_debug_display #(.DIGITS(8), .NUM_SRC(4), .SCAN_DIV(4), .DEB_W(3), .LZ_BLANK(0)) dut_nolz (
      .clkIn(clk), .rst_n(rst_n), .src_data(zero_data), .btn_next(tie0), .btn_prev(tie0),
      .force_sel_en(tie0), .force_sel(tie_sel), .seven_segments(seg2),
      .dot(dot2), .anodes(anodes2), .sel_o(sel2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0][6:0] model(input logic [31:0] w, input bit lz);
      logic [7:0][6:0] r;
      for (int d = 0; d < 8; d++)
         r[d] = (lz && d != 0 && (w >> (4 * d)) == 0) ? 7'h7F : glyph[w[4*d +: 4]];
      return r;
   endfunction

   // Current sample is frame cycle 'first'; each digit occupies 4 cycles
   task automatic check_cycles(input string name, input logic [7:0][6:0] e, input int dp,
                               input int first, input int last);
      for (int c = first; c <= last; c++) begin
         if (c > first) @(negedge clk);
         chk(name, {anodes, seven_segments, dot}, {~(8'b1 << (c / 4)), e[c / 4], 1'(dp != c / 4)});
      end
   endtask

   task automatic press(input logic nx, input logic pv);
      @(negedge clk);
      btn_next = nx;
      btn_prev = pv;
      repeat (12) @(negedge clk);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{2'd0, 32'h0000_00A5, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h12}};
      tv[1] = '{2'd1, 32'h1234_5678, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
      tv[2] = '{2'd2, 32'h0000_0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
      tv[3] = '{2'd3, 32'h0F00_0000, {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
      tv[4] = '{2'd0, 32'h8000_0001, {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}};
      tv[5] = '{2'd2, 32'h0000_B0C0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h40, 7'h46, 7'h40}};
      m1 = model(32'h1234_5678, 1'b1);

      repeat (3) @(negedge clk);
      chk("reset anodes", anodes, 8'hFF);
      chk("reset segs", seven_segments, 7'h7F);
      chk("reset dot", dot, 1'b1);
      chk("reset sel", sel_o, 2'd0);
      src_data[31:0]  = 32'h0000_00A5;
      src_data[63:32] = 32'h1234_5678;
      rst_n = 1'b1;

      // First frame shows the cleared snapshot; the no-blanking instance shows eight zeros
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("nolz frame", {anodes2, seg2, dot2}, {~(8'b1 << (i / 4)), 7'h40, 1'(i / 4 != 0)});
      end
      chk("nolz sel", sel2, 2'd0);
      @(negedge clk);
      check_cycles("frame a5", model(32'h0000_00A5, 1'b1), 0, 0, 31);

      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (20) @(negedge clk);
      chk("glitch sel", sel_o, 2'd0);

      btn_next = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = (sel_o == 2'd1);
      end
      btn_next = 1'b0;
      chk("next press seen", found, 1'b1);
      check_cycles("restart src1", m1, 1, 0, 31);
      repeat (20) @(negedge clk);
      chk("next once", sel_o, 2'd1);

      press(1'b0, 1'b1);
      chk("prev 1->0", sel_o, 2'd0);
      press(1'b0, 1'b1);
      chk("prev wrap", sel_o, 2'd3);
      press(1'b1, 1'b0);
      chk("next wrap", sel_o, 2'd0);
      press(1'b1, 1'b1);
      chk("both cancel", sel_o, 2'd0);

      force_sel_en = 1'b1;
      force_sel = 2'd2;
      repeat (2) @(negedge clk);
      chk("force 2", sel_o, 2'd2);
      force_sel = 2'd3;
      repeat (2) @(negedge clk);
      chk("force 3", sel_o, 2'd3);
      press(1'b1, 1'b0);
      chk("force ignores next", sel_o, 2'd3);
      press(1'b0, 1'b1);
      chk("force ignores prev", sel_o, 2'd3);

      for (int e = 0; e < 6; e++) begin
         src_data[32 * tv[e].sel +: 32] = tv[e].word;
         force_sel = tv[e].sel ^ 2'd1;
         @(negedge clk);
         force_sel = tv[e].sel;
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d sel", e), sel_o, tv[e].sel);
         check_cycles($sformatf("vec%0d frame", e), tv[e].seg, tv[e].sel, 0, 31);
      end

      src_data[63:32] = 32'h1234_5678;
      force_sel = 2'd0;
      @(negedge clk);
      force_sel = 2'd1;
      repeat (2) @(negedge clk);
      check_cycles("midframe head", m1, 1, 0, 11);
      src_data[63:32] = 32'hFFFF_FFFF;
      @(negedge clk);
      check_cycles("midframe tail", m1, 1, 12, 31);
      @(negedge clk);
      check_cycles("frame all F", model(32'hFFFF_FFFF, 1'b1), 1, 0, 31);

      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst anodes", anodes, 8'hFF);
      chk("async rst segs", seven_segments, 7'h7F);
      chk("async rst dot", dot, 1'b1);
      chk("async rst sel", sel_o, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
